// File: rtl/dispatch_queue.sv
// dispatch_queue
//   Decoupling instruction queue between the dual decoder and dispatch.
//   Circular buffer of DEPTH id_dispatch_t entries. Accepts 0-2 entries per
//   cycle in program order (valid slots compacted), presents the two oldest
//   entries to dispatch and retires 0-2 of them per cycle.
//
// Ports
//   clk        core clock
//   rst        asynchronous, active-low reset
//   flush      synchronous discard of all entries
//   pause      blocks all pops this cycle
//   push_valid per-slot push valid, slot 0 older
//   push_data  decoded entries to enqueue
//   push_ready queue can take a full 2-entry push (from registered count)
//   pop_en     per-slot retire request, in-order
//   dispatch_o two oldest entries, [0] oldest; absent slots are all-zero
//   count      registered occupancy
//   empty      count == 0

package pipeline_types;
    localparam int unsigned DECODER_WIDTH = 2;
    localparam int unsigned ISSUE_WIDTH   = 2;

    typedef struct packed {
        logic        inst_valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
    } id_dispatch_t;
endpackage

module dispatch_queue
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned DECODER_WIDTH = pipeline_types::DECODER_WIDTH,
    parameter int unsigned ISSUE_WIDTH   = pipeline_types::ISSUE_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  pause,
    input  logic         [DECODER_WIDTH-1:0]      push_valid,
    input  id_dispatch_t [DECODER_WIDTH-1:0]      push_data,
    output logic                                  push_ready,
    input  logic         [ISSUE_WIDTH-1:0]        pop_en,
    output id_dispatch_t [DECODER_WIDTH-1:0]      dispatch_o,
    output logic         [$clog2(DEPTH):0]        count,
    output logic                                  empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    id_dispatch_t   entries [DEPTH];

    logic [PW-1:0]  head_ptr;
    logic [PW-1:0]  tail_ptr;
    logic [PW-1:0]  head_ptr_p1;
    logic [PW-1:0]  tail_ptr_p1;

    logic           push_fire;
    logic [1:0]     n_push;
    logic           pop0;
    logic           pop1;
    logic [1:0]     n_pop;

    logic           wr0_en;
    logic           wr1_en;
    id_dispatch_t   wr0_data;

    // Depends on registered count only, so the decoder never sees a
    // combinational path from pop_en or its own push_valid.
    assign push_ready  = (count <= CW'(DEPTH - 2));
    assign push_fire   = push_ready && !flush;
    assign empty       = (count == '0);

    assign head_ptr_p1 = head_ptr + PW'(1);
    assign tail_ptr_p1 = tail_ptr + PW'(1);

    always_comb begin
        n_push = '0;
        if (push_fire) begin
            n_push = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
        end
    end

    // Slot 1 may only retire together with slot 0 (in-order retire).
    assign pop0  = pop_en[0] && !pause && (count != '0);
    assign pop1  = pop_en[1] && pop0 && (count >= CW'(2));
    assign n_pop = {1'b0, pop0} + {1'b0, pop1};

    // Compaction: the first valid slot always lands at tail_ptr.
    assign wr0_en   = push_fire && (push_valid[1:0] != 2'b00);
    assign wr1_en   = push_fire && (push_valid[1:0] == 2'b11);
    assign wr0_data = push_valid[0] ? push_data[0] : push_data[1];

    // Storage has no reset; only the occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            entries[tail_ptr] <= wr0_data;
        end
        if (wr1_en) begin
            entries[tail_ptr_p1] <= push_data[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PW'(n_pop);
            tail_ptr <= tail_ptr + PW'(n_push);
            count    <= count + CW'(n_push) - CW'(n_pop);
        end
    end

    // head_ptr_p1 wraps naturally, so slot 1 reads entry[0] at the top.
    always_comb begin
        dispatch_o = '0;
        if (count >= CW'(1)) begin
            dispatch_o[0] = entries[head_ptr];
        end
        if (count >= CW'(2)) begin
            dispatch_o[1] = entries[head_ptr_p1];
        end
    end

    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst) count <= CW'(DEPTH));

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst) CW'(n_pop) <= count);

    a_blocked_push_stable: assert property (
        @(posedge clk) disable iff (!rst)
        (!push_ready && !flush) |=> $stable(tail_ptr));

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: a reference queue of expected
// entries is fed on every accepted push and drained on every retire.
module tb_dispatch_queue;
    import pipeline_types::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    pause;
    logic         [1:0]      push_valid;
    id_dispatch_t [1:0]      push_data;
    logic                    push_ready;
    logic         [1:0]      pop_en;
    id_dispatch_t [1:0]      dispatch_o;
    logic         [3:0]      count;
    logic                    empty;

    int unsigned  tests = 0;
    int unsigned  fails = 0;
    id_dispatch_t sb[$];
    logic [31:0]  next_pc = 32'h1c00_0000;

    dispatch_queue #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .pause      (pause),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_en     (pop_en),
        .dispatch_o (dispatch_o),
        .count      (count),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic id_dispatch_t mk(input logic [31:0] pc);
        id_dispatch_t e;
        e.inst_valid = 1'b1;
        e.pc         = pc;
        e.inst       = $urandom;
        e.rd         = 5'($urandom_range(0, 31));
        return e;
    endfunction

    task automatic check_outputs();
        int sz;
        sz = sb.size();
        check("count", count, sz);
        check("empty", empty, sz == 0);
        check("push_ready", push_ready, sz <= 6);
        if (sz >= 1) check("slot0", dispatch_o[0], sb[0]);
        else         check("slot0_absent", dispatch_o[0], '0);
        if (sz >= 2) check("slot1", dispatch_o[1], sb[1]);
        else         check("slot1_absent", dispatch_o[1], '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_push_ready"}, push_ready, 1'b1);
        check({tag, "_valid0"}, dispatch_o[0].inst_valid, 1'b0);
        check({tag, "_valid1"}, dispatch_o[1].inst_valid, 1'b0);
    endtask

    // One cycle starting at a negedge: check visible state, drive inputs,
    // update the reference queue, advance to the next negedge.
    task automatic step(input logic [1:0] pv, input logic [1:0] pe,
                        input logic ps = 1'b0, input logic fl = 1'b0);
        id_dispatch_t d0, d1;
        int  sz;
        logic acc, p0, p1;
        check_outputs();
        sz  = sb.size();
        acc = (sz <= 6) && !fl;
        // slot 0 gets a recognisable junk PC when invalid, to catch bad compaction
        d0  = pv[0] ? mk(next_pc) : mk(32'hdead_0000);
        d1  = mk(pv[0] ? next_pc + 32'd4 : next_pc);
        push_valid = pv;
        push_data  = '{d1, d0};
        pop_en     = pe;
        pause      = ps;
        flush      = fl;
        p0 = pe[0] && !ps && (sz >= 1);
        p1 = pe[1] && p0 && (sz >= 2);
        if (fl) begin
            sb.delete();
        end else begin
            if (p0) void'(sb.pop_front());
            if (p1) void'(sb.pop_front());
            if (acc) begin
                if (pv[0]) begin sb.push_back(d0); next_pc += 32'd4; end
                if (pv[1]) begin sb.push_back(d1); next_pc += 32'd4; end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        pause      = 1'b0;
        push_valid = '0;
        push_data  = '0;
        pop_en     = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // dual push, then retire both
        step(2'b11, 2'b00);
        step(2'b00, 2'b11);
        // slot-1-only push into empty queue
        step(2'b10, 2'b00);
        step(2'b00, 2'b00);
        // fill to 6, then 8, then a blocked push
        step(2'b11, 2'b00);
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        step(2'b11, 2'b00);
        step(2'b11, 2'b00);
        step(2'b00, 2'b00);
        // drain to 3, then simultaneous dual pop and dual push
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b01);
        step(2'b11, 2'b11);
        // pop gating: slot 1 alone, paused, only one available
        step(2'b00, 2'b10);
        step(2'b00, 2'b11, 1'b1);
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b00);

        // mixed traffic to wrap both pointers several times
        for (int i = 0; i < 20; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0);
        end

        // flush with simultaneous push and pause
        step(2'b11, 2'b00);
        step(2'b11, 2'b11, 1'b1, 1'b1);
        step(2'b00, 2'b00);

        // asynchronous reset mid-stream
        step(2'b11, 2'b00);
        step(2'b11, 2'b01);
        push_valid = '0;
        pop_en     = '0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        step(2'b11, 2'b00);
        step(2'b00, 2'b01);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
